fpu_sp_subtractor_seq: RTL and testbench

Multi-cycle single-precision (IEEE-754 binary32) subtractor computing `result = a - b` with ready/valid handshakes on both sides. It complements the combinational single-precision adder: it negates `b` and runs the same unpack / align / add / normalize flow. Each alignment and normalization step takes one cycle, which keeps the logic small for area-constrained FPU lanes. It sits between the operand issue stage and the FPU writeback stage.

---
 rtl/fpu_sp_pkg.sv | 39 +++
 rtl/fpu_sp_unpack.sv | 33 +++
 rtl/fpu_sp_subtractor_seq.sv | 190 +++++++++++++++++++
 tb/tb_fpu_sp_subtractor_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fpu_sp_pkg.sv
// Shared definitions for the sequential single-precision FPU lanes.
// Holds the FSM state encoding, binary32 field widths, special constants
// and the operand record used between the unpack stage and the datapath.
package fpu_sp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADD    = 3'd3,
    NORM   = 3'd4,
    DONE   = 3'd5
  } fpu_state_t;

  // man is 25 bits: bit 24 catches the carry of an effective addition,
  // bit 23 is the hidden one.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [24:0]      man;
  } operand_t;

  // Split a binary32 word into fields; exponent 0 (zero or denormal)
  // yields a zero mantissa.
  function automatic operand_t unpack_operand(input logic [31:0] x);
    operand_t o;
    o.sign = x[31];
    o.exp  = x[30:23];
    o.man  = (x[30:23] == '0) ? 25'd0 : {2'b01, x[FRAC_W-1:0]};
    return o;
  endfunction

endpackage

// File: rtl/fpu_sp_unpack.sv
// Combinational operand unpack for the sequential subtractor.
// Ports:
//   a, b     in  32  operands; b arrives already sign-inverted
//   op1      out     operand with the larger {exp, man}
//   op2      out     the other operand
//   diff     out  8  op1.exp - op2.exp, the alignment distance
//   special  out  1  either exponent is all ones (inf/NaN)
module fpu_sp_unpack
  import fpu_sp_pkg::*;
(
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output operand_t         op1,
  output operand_t         op2,
  output logic [EXP_W-1:0] diff,
  output logic             special
);

  operand_t ua;
  operand_t ub;
  logic     swap;

  assign ua = unpack_operand(a);
  assign ub = unpack_operand(b);

  // Compare on the flushed mantissa so a denormal never outranks a zero.
  assign swap    = {ub.exp, ub.man} > {ua.exp, ua.man};
  assign op1     = swap ? ub : ua;
  assign op2     = swap ? ua : ub;
  assign diff    = op1.exp - op2.exp;
  assign special = (ua.exp == EXP_MAX) || (ub.exp == EXP_MAX);

endmodule

// File: rtl/fpu_sp_subtractor_seq.sv
// Multi-cycle binary32 subtractor: result = a - b, truncating.
// One alignment or normalization step per cycle, one operation in flight.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand handshake (ready only in IDLE)
//   a, b                 32    minuend, subtrahend
//   out_valid / out_ready      result handshake (valid only in DONE)
//   result               32    a - b
//   overflow_underflow_flag    saturated to inf, flushed to zero, or inf/NaN input
module fpu_sp_subtractor_seq
  import fpu_sp_pkg::*;
#(
  parameter int MAX_SHIFT = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow_underflow_flag
);

  localparam logic [EXP_W-1:0] MAX_SHIFT_D = EXP_W'(MAX_SHIFT);

  fpu_state_t       state_reg, state_next;
  logic [31:0]      a_reg, a_next;
  logic [31:0]      b_reg, b_next;
  logic             sign1_reg, sign1_next;
  logic             sign2_reg, sign2_next;
  logic [EXP_W-1:0] exp_reg, exp_next;
  logic [24:0]      m1_reg, m1_next;   // op1 mantissa, then the running sum
  logic [24:0]      m2_reg, m2_next;
  logic [EXP_W-1:0] d_reg, d_next;
  logic [31:0]      result_reg, result_next;
  logic             flag_reg, flag_next;

  operand_t         op1, op2;
  logic [EXP_W-1:0] diff;
  logic             special;
  logic [24:0]      m_sum;

  fpu_sp_unpack u_unpack (
    .a       (a_reg),
    .b       ({~b_reg[31], b_reg[30:0]}),
    .op1     (op1),
    .op2     (op2),
    .diff    (diff),
    .special (special)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sign1_reg  <= 1'b0;
      sign2_reg  <= 1'b0;
      exp_reg    <= '0;
      m1_reg     <= '0;
      m2_reg     <= '0;
      d_reg      <= '0;
      result_reg <= '0;
      flag_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      sign1_reg  <= sign1_next;
      sign2_reg  <= sign2_next;
      exp_reg    <= exp_next;
      m1_reg     <= m1_next;
      m2_reg     <= m2_next;
      d_reg      <= d_next;
      result_reg <= result_next;
      flag_reg   <= flag_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    sign1_next  = sign1_reg;
    sign2_next  = sign2_reg;
    exp_next    = exp_reg;
    m1_next     = m1_reg;
    m2_next     = m2_reg;
    d_next      = d_reg;
    result_next = result_reg;
    flag_next   = flag_reg;
    m_sum       = (sign1_reg == sign2_reg) ? (m1_reg + m2_reg) : (m1_reg - m2_reg);

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          state_next = UNPACK;
        end
      end

      UNPACK: begin
        if (special) begin
          result_next = QNAN;
          flag_next   = 1'b1;
          state_next  = DONE;
        end else begin
          sign1_next = op1.sign;
          sign2_next = op2.sign;
          exp_next   = op1.exp;
          m1_next    = op1.man;
          m2_next    = op2.man;
          d_next     = diff;
          state_next = ALIGN;
        end
      end

      ALIGN: begin
        if (d_reg >= MAX_SHIFT_D) begin
          m2_next    = '0;
          d_next     = '0;
          state_next = ADD;
        end else begin
          if (d_reg != '0) begin
            m2_next = m2_reg >> 1;
            d_next  = d_reg - 1'b1;
          end
          // d of 0 or 1 both leave after this cycle: max(1, d) cycles total.
          if (d_reg <= 8'd1) begin
            state_next = ADD;
          end
        end
      end

      ADD: begin
        // op1 holds the larger magnitude, so the difference never goes negative.
        if (m_sum == '0) begin
          result_next = '0;
          flag_next   = 1'b0;
          state_next  = DONE;
        end else begin
          m1_next    = m_sum;
          state_next = NORM;
        end
      end

      NORM: begin
        if (m1_reg[24]) begin
          m1_next  = m1_reg >> 1;
          exp_next = exp_reg + 1'b1;
          if (exp_reg == EXP_MAX - 1'b1) begin
            result_next = {sign1_reg, EXP_MAX, 23'h0};
            flag_next   = 1'b1;
            state_next  = DONE;
          end
        end else if (!m1_reg[23]) begin
          m1_next  = m1_reg << 1;
          exp_next = exp_reg - 1'b1;
          if (exp_reg == 8'd1) begin
            result_next = {sign1_reg, 31'h0};
            flag_next   = 1'b1;
            state_next  = DONE;
          end
        end else begin
          result_next = {sign1_reg, exp_reg, m1_reg[22:0]};
          flag_next   = 1'b0;
          state_next  = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready                = (state_reg == IDLE);
  assign out_valid               = (state_reg == DONE);
  assign result                  = result_reg;
  assign overflow_underflow_flag = flag_reg;

endmodule

// File: tb/tb_fpu_sp_subtractor_seq.sv
// Directed bench for fpu_sp_subtractor_seq: hand-computed results, flags
// and accept-to-valid latencies, plus backpressure and mid-operation reset.
module tb_fpu_sp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow_underflow_flag;

  int total = 0;
  int bad   = 0;

  fpu_sp_subtractor_seq #(.MAX_SHIFT(25)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .a                       (a),
    .b                       (b),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .result                  (result),
    .overflow_underflow_flag (overflow_underflow_flag)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for out_valid, check result/flag/latency,
  // optionally stall the consumer for hold cycles, then handshake.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_res, input logic exp_flag,
                        input int exp_lat, input int hold);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1;
    end
    check_val({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check_val({tag, "_res"}, result, exp_res);
    check_val({tag, "_flag"}, {31'b0, overflow_underflow_flag}, {31'b0, exp_flag});
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_hold_res"}, result, exp_res);
      check_val({tag, "_hold_rdy"}, {31'b0, in_ready}, 32'd0);
      check_val({tag, "_hold_vld"}, {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_back_idle"}, {31'b0, in_ready}, 32'd1);
    $display("op %s a=%h b=%h result=%h flag=%0d lat=%0d", tag, av, bv, result,
             overflow_underflow_flag, lat);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_result", result, 32'h0);
    check_val("rst_flag", {31'b0, overflow_underflow_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("3m1",     32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4, 0);
    run_op("1mneg1",  32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 5, 0);
    run_op("1m1",     32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 3, 0);
    run_op("ovf",     32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 4, 0);
    run_op("unf",     32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 1'b1, 4, 0);
    run_op("d24",     32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0, 27, 0);
    run_op("d25",     32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 1'b0, 4, 0);
    run_op("inf",     32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1, 0);
    run_op("1m3",     32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 1'b0, 4, 0);
    run_op("bp5m2",   32'h40A0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 5, 10);

    // Abort mid-ALIGN (d=24 keeps the block there for many cycles).
    @(negedge clk);
    a        = 32'h4B80_0000;
    b        = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check_val("abort_result", result, 32'h0);
    $display("op abort_in_align out_valid=%0d in_ready=%0d result=%h", out_valid, in_ready, result);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
